// File: rtl/bridge_pkg.sv
// bridge_pkg: shared types, AHB codes, APB slave address map and decode helper.
package bridge_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_RENABLE,
    ST_WWAIT,
    ST_WRITE,
    ST_WENABLE,
    ST_ERR1,
    ST_ERR2
  } state_e;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [31:0] S0_BASE  = 32'h8000_0000;
  localparam logic [31:0] S0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] S1_BASE  = 32'h8400_0000;
  localparam logic [31:0] S1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] S2_BASE  = 32'h8800_0000;
  localparam logic [31:0] S2_LIMIT = 32'h8BFF_FFFF;
  function automatic logic [2:0] decode_sel(input logic [31:0] a);
    return (a >= S0_BASE && a <= S0_LIMIT) ? 3'b001 :
           (a >= S1_BASE && a <= S1_LIMIT) ? 3'b010 :
           (a >= S2_BASE && a <= S2_LIMIT) ? 3'b100 : 3'b000;
  endfunction
endpackage

// File: rtl/bridge_ahb_slave_if.sv
// ahb_slave_if: AHB address-phase decode, transfer qualification and pipeline registers.
// Ports: clk/rst; htrans, haddr, hwrite, hreadyin from AHB; accept (bridge ready to take a
// new address phase); valid/err_req/sel are the live qualification and decode; haddr_q,
// hwrite_q, sel_q hold the last accepted address phase.
module ahb_slave_if
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hreadyin,
  input  logic        hwrite,
  input  logic        accept,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  output logic        valid,
  output logic        err_req,
  output logic [2:0]  sel,
  output logic [2:0]  sel_q,
  output logic [31:0] haddr_q,
  output logic        hwrite_q
);
  logic        active;
  logic        cap;
  logic [2:0]  sel_d;
  logic [31:0] haddr_d;
  logic        hwrite_d;
  always_comb begin
    active   = hreadyin && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    sel      = decode_sel(haddr);
    valid    = active && |sel;
    err_req  = active && ~|sel;
    cap      = valid && accept;
    sel_d    = cap ? sel : sel_q;
    haddr_d  = cap ? haddr : haddr_q;
    hwrite_d = cap ? hwrite : hwrite_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= '0;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
    end
  end
endmodule

// File: rtl/bridge_top.sv
// bridge_top: AHB-to-APB bridge with three APB slaves and registered APB outputs.
// Ports: Hclk, Hreset (sync, active-high); AHB side Hwrite, Hreadyin, Htrans, Haddr, Hwdata
// in and Hreadyout, Hresp, Hrdata out; APB side Prdata in and Pselx, Penable, Pwrite, Paddr,
// Pwdata out.
// Macro BRIDGE_ERROR_RESP_EN: when defined, transfers to unmapped addresses get a two-cycle
// AHB ERROR response; otherwise they are silently ignored.
module bridge_top
  import bridge_pkg::*;
(
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Prdata,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic [31:0] Hrdata,
  output logic [2:0]  Pselx,
  output logic        Penable,
  output logic        Pwrite,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata
);
  state_e      state_q, state_d;
  logic [2:0]  pselx_q, pselx_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        accept, valid, err_req, hwrite_q;
  logic [2:0]  sel, sel_q;
  logic [31:0] haddr_q;
  ahb_slave_if u_if (
    .clk      (Hclk),
    .rst      (Hreset),
    .hreadyin (Hreadyin),
    .hwrite   (Hwrite),
    .accept   (accept),
    .htrans   (Htrans),
    .haddr    (Haddr),
    .valid    (valid),
    .err_req  (err_req),
    .sel      (sel),
    .sel_q    (sel_q),
    .haddr_q  (haddr_q),
    .hwrite_q (hwrite_q)
  );
  // A new address phase can only be taken where the bridge shows ready to the master.
  assign accept = state_q == ST_IDLE || state_q == ST_RENABLE || state_q == ST_WENABLE;
  assign Hrdata = Prdata;
`ifdef BRIDGE_ERROR_RESP_EN
  assign Hreadyout = accept || state_q == ST_ERR2;
  assign Hresp     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
`else
  logic unused_err;
  assign unused_err = err_req;
  assign Hreadyout  = accept;
  assign Hresp      = HRESP_OKAY;
`endif
  always_comb begin
    state_d   = state_q;
    pselx_d   = pselx_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    case (state_q)
      ST_WWAIT: begin
        // Write data arrives now; load the whole APB setup phase from the captured address.
        state_d  = ST_WRITE;
        pselx_d  = sel_q;
        paddr_d  = haddr_q;
        pwdata_d = Hwdata;
        pwrite_d = hwrite_q;
      end
      ST_WRITE: begin
        state_d   = ST_WENABLE;
        penable_d = 1'b1;
      end
      ST_READ: begin
        state_d   = ST_RENABLE;
        penable_d = 1'b1;
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ST_IDLE;
      default: begin
        pselx_d   = '0;
        penable_d = 1'b0;
`ifdef BRIDGE_ERROR_RESP_EN
        state_d = valid ? (Hwrite ? ST_WWAIT : ST_READ) : (err_req ? ST_ERR1 : ST_IDLE);
`else
        state_d = valid ? (Hwrite ? ST_WWAIT : ST_READ) : ST_IDLE;
`endif
        // Reads need no data phase, so their APB setup is loaded straight from the bus.
        if (valid && !Hwrite) begin
          pselx_d  = sel;
          paddr_d  = Haddr;
          pwrite_d = 1'b0;
        end
      end
    endcase
  end
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q   <= ST_IDLE;
      pselx_q   <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      pselx_q   <= pselx_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end
  assign Pselx   = pselx_q;
  assign Penable = penable_q;
  assign Pwrite  = pwrite_q;
  assign Paddr   = paddr_q;
  assign Pwdata  = pwdata_q;
endmodule

// File: tb/tb_bridge_top.sv
// tb_bridge_top: scoreboard bench for the AHB-to-APB bridge.
module tb_bridge_top;
  logic        Hclk = 1'b0, Hreset = 1'b1, Hwrite = 1'b0, Hreadyin = 1'b1;
  logic [1:0]  Htrans = 2'b00;
  logic [31:0] Haddr = '0, Hwdata = '0, Prdata;
  logic        Hreadyout, Penable, Pwrite;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata, Paddr, Pwdata;
  logic [2:0]  Pselx;
  bridge_top dut (
    .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin), .Htrans(Htrans),
    .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata), .Hreadyout(Hreadyout), .Hresp(Hresp),
    .Hrdata(Hrdata), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr),
    .Pwdata(Pwdata)
  );
  always #5 Hclk = ~Hclk;
  int cyc = 0;
  always @(posedge Hclk) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  typedef struct {
    logic        wr;
    logic [2:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return a == 32'h8000_00A2 ? 32'h1234_5678 : a ^ 32'hC3C3_3C3C;
  endfunction
  function automatic logic [2:0] sel_model(input logic [31:0] a);
    logic [5:0] t;
    t = a[31:26];
    return t == 6'b100000 ? 3'b001 : t == 6'b100001 ? 3'b010 : t == 6'b100010 ? 3'b100 : 3'b000;
  endfunction
  assign Prdata = rd_model(Paddr);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wait_ready();
    for (int i = 0; i < 10 && Hreadyout !== 1'b1; i++) @(posedge Hclk) #1;
    check("ready_wait", Hreadyout, 1);
  endtask
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    wait_ready();
    Htrans = 2'b10;
    Haddr  = a;
    Hwrite = w;
    sb.push_back('{w, sel_model(a), a, w ? d : rd_model(a), cyc + (w ? 3 : 2)});
    @(posedge Hclk) #1;
    Htrans = 2'b00;
    Hwdata = d;
  endtask
  always @(negedge Hclk) begin
    if (Pselx != 3'b000 && Penable === 1'b0) begin
      if (sb.size() == 0) check("setup_spurious", {29'd0, Pselx}, 0);
      else begin
        e = sb[0];
        check("setup_sel", {29'd0, Pselx}, {29'd0, e.sel});
        check("setup_addr", Paddr, e.addr);
        check("setup_wr", {31'd0, Pwrite}, {31'd0, e.wr});
        check("setup_cyc", cyc, e.cyc - 1);
        check("setup_rdy", {31'd0, Hreadyout}, 0);
        if (e.wr) check("setup_wdata", Pwdata, e.data);
      end
    end
    if (Penable === 1'b1) begin
      if (sb.size() == 0) check("enable_spurious", {31'd0, Penable}, 0);
      else begin
        e = sb.pop_front();
        check("en_sel", {29'd0, Pselx}, {29'd0, e.sel});
        check("en_addr", Paddr, e.addr);
        check("en_wr", {31'd0, Pwrite}, {31'd0, e.wr});
        check("en_cyc", cyc, e.cyc);
        check("en_rdy", {31'd0, Hreadyout}, 1);
        check("en_resp", {30'd0, Hresp}, 0);
        if (e.wr) check("en_wdata", Pwdata, e.data);
        else check("hrdata", Hrdata, e.data);
      end
    end
  end
  logic [31:0] bases [3] = '{32'h8000_0000, 32'h8400_0000, 32'h8800_0000};
  logic [31:0] unmapped [2] = '{32'h8C00_0000, 32'h7FFF_FFFF};
  initial begin
    repeat (3) @(posedge Hclk);
    #1 Hreset = 1'b0;
    @(posedge Hclk) #1;
    check("rst_rdy", {31'd0, Hreadyout}, 1);
    check("rst_resp", {30'd0, Hresp}, 0);
    check("rst_sel", {29'd0, Pselx}, 0);
    check("rst_en", {31'd0, Penable}, 0);
    check("rst_pwrite", {31'd0, Pwrite}, 0);
    check("rst_paddr", Paddr, 0);
    check("rst_pwdata", Pwdata, 0);
    issue(1'b1, 32'h8000_0001, 32'hA5A5_A5A5);
    issue(1'b0, 32'h8000_00A2, 32'h0);
    issue(1'b0, 32'h8400_0010, 32'h0);
    issue(1'b0, 32'h8800_0020, 32'h0);
    issue(1'b0, 32'h83FF_FFFF, 32'h0);
    issue(1'b1, 32'h8400_0000, 32'h1111_2222);
    issue(1'b0, 32'h8BFF_FFFF, 32'h0);
    wait_ready();
    Htrans = 2'b10; Hreadyin = 1'b0; Haddr = 32'h8000_0010; Hwrite = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge Hclk) #1;
      check("nop_sel", {29'd0, Pselx}, 0);
      check("nop_rdy", {31'd0, Hreadyout}, 1);
      Hreadyin = 1'b1;
      Htrans = k == 0 ? 2'b00 : 2'b01;
    end
    Htrans = 2'b00;
    @(posedge Hclk) #1;
    check("nop_en", {31'd0, Penable}, 0);
    foreach (unmapped[j]) begin
      wait_ready();
      Htrans = 2'b10; Haddr = unmapped[j]; Hwrite = 1'b1;
      @(posedge Hclk) #1;
      Htrans = 2'b00;
`ifdef BRIDGE_ERROR_RESP_EN
      check("err1_resp", {30'd0, Hresp}, 1);
      check("err1_rdy", {31'd0, Hreadyout}, 0);
      @(posedge Hclk) #1;
      check("err2_resp", {30'd0, Hresp}, 1);
      check("err2_rdy", {31'd0, Hreadyout}, 1);
      @(posedge Hclk) #1;
      check("err3_resp", {30'd0, Hresp}, 0);
`else
      check("unm_resp", {30'd0, Hresp}, 0);
      check("unm_rdy", {31'd0, Hreadyout}, 1);
      @(posedge Hclk) #1;
      check("unm_resp2", {30'd0, Hresp}, 0);
`endif
      check("unm_sel", {29'd0, Pselx}, 0);
    end
    for (int n = 0; n < 12; n++)
      issue(1'($urandom_range(0, 1)), bases[$urandom_range(0, 2)] + $urandom_range(0, 32'h03FF_FFFF), $urandom);
    issue(1'b1, 32'h8800_0040, 32'h0BAD_F00D);
    for (int i = 0; i < 6 && Penable !== 1'b1; i++) @(posedge Hclk) #1;
    check("wen_reached", {31'd0, Penable}, 1);
    Hreset = 1'b1;
    @(posedge Hclk) #1;
    check("mid_rst_en", {31'd0, Penable}, 0);
    check("mid_rst_sel", {29'd0, Pselx}, 0);
    check("mid_rst_rdy", {31'd0, Hreadyout}, 1);
    Hreset = 1'b0;
    issue(1'b0, 32'h8000_0004, 32'h0);
    repeat (5) @(posedge Hclk);
    #1 check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bridge_top.md
BRIDGE_TOP -- requirements
Module: bridge_top

Interface
REQ-001 Hclk  in  1  sole clock; all state updates on rising edge.
REQ-002 Hreset  in  1  synchronous, active-high reset.
REQ-003 Hwrite  in  1  AHB direction; 1=write, 0=read.
REQ-004 Hreadyin  in  1  AHB ready from the bus; a transfer is accepted only when 1.
REQ-005 Htrans  in  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-006 Haddr  in  32  AHB address.
REQ-007 Hwdata  in  32  AHB write data, valid in the data phase, one cycle after the address phase.
REQ-008 Prdata  in  32  APB read data from the selected peripheral.
REQ-009 Hreadyout  out  1  bridge ready to AHB; 0 stalls the master.
REQ-010 Hresp  out  2  AHB response; 00 OKAY, 01 ERROR.
REQ-011 Hrdata  out  32  AHB read data.
REQ-012 Pselx  out  3  one-hot APB peripheral select.
REQ-013 Penable  out  1  APB enable strobe.
REQ-014 Pwrite  out  1  APB direction.
REQ-015 Paddr  out  32  APB address.
REQ-016 Pwdata  out  32  APB write data.

Function
REQ-017 Decode: 0x8000_0000-0x83FF_FFFF -> Pselx 001; 0x8400_0000-0x87FF_FFFF -> 010; 0x8800_0000-0x8BFF_FFFF -> 100; any other address -> 000.
REQ-018 Valid transfer: Hreadyin=1, Htrans is NONSEQ or SEQ, and the address lies in 0x8000_0000-0x8BFF_FFFF; IDLE and BUSY transfers are ignored.
REQ-019 When a valid transfer is accepted, the bridge registers Haddr, Hwrite and the decoded select.
REQ-020 FSM states: IDLE, READ, RENABLE, WWAIT, WRITE, WENABLE.
REQ-021 From IDLE: valid read -> READ; valid write -> WWAIT; otherwise stay in IDLE.
REQ-022 WWAIT: register Hwdata, then go to WRITE.
REQ-023 WRITE (APB setup): Pselx=decoded select, Paddr=registered address, Pwdata=registered data, Pwrite=1, Penable=0; go to WENABLE.
REQ-024 WENABLE: Penable=1 with Pselx, Paddr, Pwdata and Pwrite held.
REQ-025 READ (APB setup): Pselx=decoded select, Paddr=registered address, Pwrite=0, Penable=0; go to RENABLE.
REQ-026 RENABLE: Penable=1 with all other APB outputs held.
REQ-027 From WENABLE or RENABLE: a new valid transfer sampled in that cycle goes to READ or WWAIT, as from IDLE; otherwise go to IDLE, where Pselx=000, Penable=0 and Paddr, Pwdata, Pwrite hold their last values.
REQ-028 Hreadyout is decoded from state: 1 in IDLE, WENABLE and RENABLE; 0 otherwise.
REQ-029 APB outputs are registered.
REQ-030 Hrdata is combinationally equal to Prdata at all times.
REQ-031 Read latency: address phase in cycle 0; APB setup in cycle 1; enable in cycle 2 with Hreadyout=1 and Hrdata valid.
REQ-032 Write latency: address phase in cycle 0; WWAIT in cycle 1; setup in cycle 2; enable in cycle 3 with Hreadyout=1.
REQ-033 Hresp is 00 in all cases except those covered by REQ-037.

Reset
REQ-034 Hreset=1 at a rising edge forces IDLE, including mid-transfer; the in-flight APB transfer is abandoned.
REQ-035 Reset values: Hreadyout=1, Hresp=00, Pselx=000, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, and all internal registers 0.

Configuration
REQ-036 Macro BRIDGE_ERROR_RESP_EN controls the unmapped-address error response.
REQ-037 With BRIDGE_ERROR_RESP_EN defined: a NONSEQ/SEQ transfer with Hreadyin=1 to an unmapped address gives a two-cycle AHB ERROR response (cycle 1: Hresp=01, Hreadyout=0; cycle 2: Hresp=01, Hreadyout=1); no APB access is made.
REQ-038 Without BRIDGE_ERROR_RESP_EN: such a transfer is ignored and Hresp stays 00.

Structure
REQ-039 Package bridge_pkg holds: state enum, HTRANS codes, slave base and limit addresses, and Hresp codes.
REQ-040 Sub-module ahb_slave_if holds the pipeline registers, address decode and valid logic; the FSM lives in bridge_top.

Verification
REQ-041 Reset held, then released -> Hreadyout=1, Pselx=000, Penable=0, Hresp=00.
REQ-042 NONSEQ write to 0x8000_0001 with Hwdata=0xA5A5_A5A5 -> setup in cycle 2 (Pselx=001, Pwrite=1, Paddr=0x8000_0001, Pwdata=0xA5A5_A5A5), enable in cycle 3, Hreadyout=1 in cycle 3.
REQ-043 NONSEQ read from 0x8000_00A2 with Prdata=0x1234_5678 -> Pselx=001, Pwrite=0, Penable=1 in cycle 2, Hrdata=0x1234_5678 when Hreadyout=1.
REQ-044 Read from 0x8400_0010, then read from 0x8800_0020 issued during RENABLE -> Pselx=010 for the first, then Pselx=100 for the second with no IDLE gap.
REQ-045 Htrans=00 or Hreadyin=0 with a mapped address -> no APB activity; FSM stays in IDLE.
REQ-046 Hreset asserted during WENABLE -> next edge: IDLE, Penable=0, Pselx=000.
